// File: rtl/rv_mem_arbiter.sv
// Single-port BRAM arbiter between instruction fetch (read-only) and the LSU.
// LSU has priority; a saturating starvation counter periodically forces a fetch grant.
module rv_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,

  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              pend_if_q, pend_ls_q;
  logic [DATA_W-1:0] hold_if_q, hold_ls_q;
  logic              starved;

  assign starved = (starve_q == CNT_MAX);

  // Grant selection: LSU wins unless fetch has waited through STARVE_MAX LSU grants.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (ls_req && !(if_req && starved)) begin
        ls_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (if_gnt || !if_req) begin
      starve_d = '0;
    end else if (ls_gnt && !starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Memory port driven straight from the winner so the access lands this cycle.
  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = (ls_gnt && ls_we) ? ls_be : {BE_W{1'b0}};
    mem_addr  = '0;
    if (ls_gnt) begin
      mem_addr = ls_addr;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
    mem_wdata = rst ? {DATA_W{1'b0}} : ls_wdata;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      starve_q  <= '0;
      pend_if_q <= 1'b0;
      pend_ls_q <= 1'b0;
      hold_if_q <= '0;
      hold_ls_q <= '0;
    end else begin
      starve_q  <= starve_d;
      pend_if_q <= if_gnt;
      pend_ls_q <= ls_gnt && !ls_we;
      if (pend_if_q) begin
        hold_if_q <= mem_rdata;
      end
      if (pend_ls_q) begin
        hold_ls_q <= mem_rdata;
      end
    end
  end

  // A reset arriving the cycle after a grant suppresses the pending response.
  assign if_rvalid = pend_if_q && !rst;
  assign ls_rvalid = pend_ls_q && !rst;
  assign if_rdata  = rst ? {DATA_W{1'b0}} : (pend_if_q ? mem_rdata : hold_if_q);
  assign ls_rdata  = rst ? {DATA_W{1'b0}} : (pend_ls_q ? mem_rdata : hold_ls_q);

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter with a behavioural BRAM and a per-cycle
// reference model of grants, memory drive and read returns.
module tb_rv_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [BW-1:0] ls_be = '0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port BRAM with byte write enables.
  logic [DW-1:0] bram [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == '0) mem_rdata <= bram[mem_addr];
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) bram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: contents as seen by the requesters, LS grants taken
  // while fetch waited since its last grant, and outstanding read results.
  logic [DW-1:0] shadow [1024];
  int            streak = 0;
  bit            m_if_pend = 0, m_ls_pend = 0;
  logic [DW-1:0] m_if_val = '0, m_ls_val = '0, m_if_hold = '0, m_ls_hold = '0;
  bit            rec = 0;
  string         trace = "";

  task automatic model_step();
    bit e_if, e_ls;
    logic [BW-1:0] e_we;
    if (rst) begin
      e_if = 0; e_ls = 0;
    end else if (if_req && ls_req) begin
      e_ls = (streak < SM);
      e_if = !e_ls;
    end else begin
      e_ls = ls_req; e_if = if_req;
    end
    e_we = (e_ls && ls_we) ? ls_be : '0;

    check("if_gnt", 32'(if_gnt), 32'(e_if));
    check("ls_gnt", 32'(ls_gnt), 32'(e_ls));
    check("mem_en", 32'(mem_en), 32'(e_if || e_ls));
    check("mem_we", 32'(mem_we), 32'(e_we));
    if (e_ls)      check("mem_addr", 32'(mem_addr), 32'(ls_addr));
    else if (e_if) check("mem_addr", 32'(mem_addr), 32'(if_addr));
    else if (rst)  check("mem_addr", 32'(mem_addr), 32'd0);
    check("mem_wdata", mem_wdata, rst ? 32'd0 : ls_wdata);
    check("if_rvalid", 32'(if_rvalid), 32'(m_if_pend && !rst));
    check("ls_rvalid", 32'(ls_rvalid), 32'(m_ls_pend && !rst));
    check("if_rdata", if_rdata, rst ? 32'd0 : (m_if_pend ? m_if_val : m_if_hold));
    check("ls_rdata", ls_rdata, rst ? 32'd0 : (m_ls_pend ? m_ls_val : m_ls_hold));

    if (rec) trace = {trace, ls_gnt ? "L" : (if_gnt ? "I" : "-")};

    if (rst) begin
      streak = 0; m_if_pend = 0; m_ls_pend = 0; m_if_hold = '0; m_ls_hold = '0;
    end else begin
      if (m_if_pend) m_if_hold = m_if_val;
      if (m_ls_pend) m_ls_hold = m_ls_val;
      m_if_pend = e_if;
      m_ls_pend = e_ls && !ls_we;
      if (e_if) m_if_val = shadow[if_addr];
      if (m_ls_pend) m_ls_val = shadow[ls_addr];
      if (e_ls && ls_we)
        for (int b = 0; b < BW; b++)
          if (ls_be[b]) shadow[ls_addr][b*8 +: 8] = ls_wdata[b*8 +: 8];
      if (e_if || !if_req) streak = 0;
      else if (e_ls) streak++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0; ls_req = 0; ls_we = 0; ls_be = '0;
  endtask

  task automatic ls_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    ls_req = 1; ls_we = 1; ls_be = be; ls_addr = a; ls_wdata = d;
    sample();
    check("setup_ls_gnt", 32'(ls_gnt), 32'd1);
    next();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_if;

    // Reset held with both requesting; LS carries a write of word 0x001.
    rst = 1; if_req = 1; if_addr = 10'h001;
    ls_req = 1; ls_we = 1; ls_be = 4'hF; ls_addr = 10'h001; ls_wdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rst_gnts", 32'({if_gnt, ls_gnt}), 32'd0);
      check("rst_rvalids", 32'({if_rvalid, ls_rvalid}), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      next();
    end
    rst = 0;
    sample();
    check("post_rst_ls_first", 32'({ls_gnt, if_gnt}), 32'b10);
    next();
    ls_req = 0; ls_we = 0;
    sample();
    check("post_rst_if_gnt", 32'(if_gnt), 32'd1);
    next();
    idle();
    sample();
    check("wr_then_rd", if_rdata, 32'h11111111);
    next();

    ls_write(10'h002, 32'h22222222, 4'hF);
    ls_write(10'h010, 32'h00500093, 4'hF);
    ls_write(10'h020, 32'h00000000, 4'hF);

    // Fetch alone.
    if_req = 1; if_addr = 10'h010;
    sample();
    check("fetch_gnt", 32'(if_gnt), 32'd1);
    next();
    if_req = 0;
    sample();
    check("fetch_rvalid", 32'(if_rvalid), 32'd1);
    check("fetch_rdata", if_rdata, 32'h00500093);
    next();
    sample();
    check("fetch_rvalid_drop", 32'(if_rvalid), 32'd0);
    check("fetch_rdata_hold", if_rdata, 32'h00500093);
    next();

    // Partial write then read back.
    ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 10'h020; ls_wdata = 32'hDEADBEEF;
    sample();
    check("pw_mem_we", 32'(mem_we), 32'h3);
    next();
    ls_we = 0; ls_be = '0;
    sample();
    check("pw_no_rvalid", 32'(ls_rvalid), 32'd0);
    check("pw_rd_gnt", 32'(ls_gnt), 32'd1);
    next();
    idle();
    sample();
    check("pw_rd_rvalid", 32'(ls_rvalid), 32'd1);
    check("pw_rd_data", ls_rdata, 32'h0000BEEF);
    next();

    // Contention for 15 cycles.
    rec = 1; prev_if = 0;
    if_req = 1; if_addr = 10'h010;
    ls_req = 1; ls_we = 0; ls_addr = 10'h020;
    for (int i = 0; i < 15; i++) begin
      sample();
      if (prev_if) check("starve_clr", 32'(dut.starve_q), 32'd0);
      prev_if = if_gnt;
      next();
    end
    rec = 0;
    idle();
    sample();
    if (prev_if) check("starve_clr", 32'(dut.starve_q), 32'd0);
    next();
    tests++;
    if (trace != "LLLLILLLLILLLLI") begin
      fails++;
      $display("FAIL grant_seq: got %s, expected LLLLILLLLILLLLI", trace);
    end

    // Interleaved reads to both ports.
    if_req = 1; if_addr = 10'h001;
    sample();
    check("il_if_gnt", 32'(if_gnt), 32'd1);
    next();
    if_req = 0; ls_req = 1; ls_we = 0; ls_addr = 10'h002;
    sample();
    check("il_ls_gnt", 32'(ls_gnt), 32'd1);
    check("il_n1_valids", 32'({if_rvalid, ls_rvalid}), 32'b10);
    check("il_if_rdata", if_rdata, 32'h11111111);
    next();
    idle();
    sample();
    check("il_n2_valids", 32'({if_rvalid, ls_rvalid}), 32'b01);
    check("il_ls_rdata", ls_rdata, 32'h22222222);
    next();

    // Reset the cycle after a fetch grant.
    if_req = 1; if_addr = 10'h010;
    sample();
    check("rg_if_gnt", 32'(if_gnt), 32'd1);
    next();
    if_req = 0; rst = 1;
    sample();
    check("rg_rvalid", 32'(if_rvalid), 32'd0);
    check("rg_rdata", if_rdata, 32'd0);
    next();
    rst = 0;
    sample();
    check("rg_rvalid_after", 32'(if_rvalid), 32'd0);
    check("rg_rdata_after", if_rdata, 32'd0);
    next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Arbitrates one single-port synchronous instruction/data BRAM between the fetch unit (read-only) and the load/store unit (read/write with byte enables) inside `rv_core`. LSU has priority, and a starvation guard periodically forces a fetch grant. Read data returns one cycle after grant and is routed to the requester that issued the read. The block lets the core run from a unified memory image loaded at simulation start.

## Interface

Parameters:
- `ADDR_W`, 10, word-address width.
- `DATA_W`, 32, data width; must be a multiple of 8.
- `STARVE_MAX`, 4, consecutive LSU grants allowed while fetch waits; minimum 1.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `if_req`  in  1  fetch read request.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch read data valid.
- `if_rdata`  out  DATA_W  fetch read data; holds last valid value.
- `ls_req`  in  1  LSU request.
- `ls_we`  in  1  1 = write, 0 = read.
- `ls_be`  in  DATA_W/8  write byte enables.
- `ls_addr`  in  ADDR_W  LSU word address.
- `ls_wdata`  in  DATA_W  write data.
- `ls_gnt`  out  1  LSU request accepted this cycle.
- `ls_rvalid`  out  1  LSU read data valid; never asserted for writes.
- `ls_rdata`  out  DATA_W  LSU read data; holds last valid value.
- `mem_en`  out  1  BRAM enable.
- `mem_we`  out  DATA_W/8  BRAM byte write enables.
- `mem_addr`  out  ADDR_W  BRAM address.
- `mem_wdata`  out  DATA_W  BRAM write data.
- `mem_rdata`  in  DATA_W  BRAM read data, valid one cycle after `mem_en` with `mem_we` = 0.

## Operation

- **Requester protocol:** a requester holds req, address, we, be and wdata stable until the cycle its gnt is high. It may drop req only after gnt. It may issue a new request in the cycle after gnt.
- **Grant rule, combinational each cycle:**
  - Only `ls_req`: LS wins.
  - Only `if_req`: IF wins.
  - Both high and `starve_cnt < STARVE_MAX`: LS wins.
  - Both high and `starve_cnt == STARVE_MAX`: IF wins.
  - `rst` high forces both gnt to 0.
- **starve_cnt (registered, range 0..STARVE_MAX):**
  - Increments when LS is granted while `if_req` is high. Saturates at STARVE_MAX.
  - Clears when IF is granted or `if_req` is low.
- **Memory drive, combinational from the winner:**
  - `mem_en` = any grant.
  - `mem_addr` = winner's address.
  - `mem_we` = `ls_be` if the LS write wins, else 0.
  - `mem_wdata` = `ls_wdata`.
  - With no grant, `mem_we` = 0 and `mem_en` = 0.
- **Read return:**
  - Registered flags `pend_if` and `pend_ls` are set for a granted read and cleared otherwise.
  - `if_rvalid` = `pend_if` and `ls_rvalid` = `pend_ls`.
  - In the rvalid cycle, the rdata of that port equals `mem_rdata`.
  - A per-port hold register captures `mem_rdata` when that port's pend flag is set. rdata outputs the captured value in later cycles.
- **Writes:** completion equals gnt; no response cycle.

## Timing

- Grant latency is 0 cycles: gnt in the same cycle as req when it wins.
- Read latency is 1 cycle: grant at cycle N gives rvalid at N+1.
- Throughput is one access per cycle. Back-to-back reads to alternating ports return in order, each routed by its pend flag.
- **Reset values:** all gnt = 0; `if_rvalid` = `ls_rvalid` = 0; `mem_en` = 0; `mem_we` = 0; `mem_addr` = 0; `mem_wdata` = 0; `pend_if` = `pend_ls` = 0; `starve_cnt` = 0; both rdata holds = 0.
- **Reset mid-operation:** a read granted at N with `rst` high at N+1 produces no rvalid, and the hold registers are cleared. Requesters must reissue after reset.
- **Fetch fairness bound:** with both requesting every cycle, at most STARVE_MAX LS grants occur between IF grants.
- An IF grant at cycle N and an LS grant at N+1 are legal. `if_rvalid` at N+1 and `ls_rvalid` at N+2 never overlap.
- A write followed by a read to the same address in the next cycle returns the newly written data. This relies on BRAM write-first or no-conflict behaviour, which is guaranteed because the accesses are sequential.

## Test plan

- **Reset:** hold `rst` for 3 cycles with `if_req` = `ls_req` = 1. Required: both gnt, both rvalid and `mem_en` are 0 throughout. After release, LS is granted on the first cycle.
- **Fetch alone:** BRAM word 0x010 = 0x00500093; `if_req` with `if_addr` = 0x010. Required: `if_gnt` in cycle N, and `if_rvalid` = 1 with `if_rdata` = 0x00500093 in N+1. `if_rdata` keeps that value after rvalid drops.
- **Partial write then read:** BRAM word 0x020 = 0. LS write `ls_be` = 4'b0011, `ls_wdata` = 0xDEADBEEF, then LS read of 0x020. Required: `mem_we` = 4'b0011 on the write, no `ls_rvalid` for the write, and read data 0x0000BEEF.
- **Contention:** `STARVE_MAX` = 4; both requesters assert every cycle for 15 cycles. Required grant sequence: LS,LS,LS,LS,IF repeated three times. `starve_cnt` is 0 after each IF grant.
- **Interleaved reads:** words 0x001 = 0x11111111 and 0x002 = 0x22222222. Sequence: IF read 0x001 at N, LS read 0x002 at N+1. Required: `if_rvalid` with 0x11111111 at N+1, and `ls_rvalid` with 0x22222222 at N+2, never simultaneous.
- **Reset after grant:** IF read granted at N, `rst` = 1 at N+1. Required: `if_rvalid` stays 0 and `if_rdata` = 0.
